// File: rtl/ctrl_pkg.sv
// Shared controller definitions: instruction opcodes, field positions and
// opcode classification helpers used by the issue queue.
package ctrl_pkg;

   // Opcode encodings (instruction bits [63:59])
   localparam logic [4:0] OP_NONE      = 5'b00000;
   localparam logic [4:0] OP_MAC       = 5'b00001;
   localparam logic [4:0] OP_SEND_WT   = 5'b00010;
   localparam logic [4:0] OP_STORE_OUT = 5'b00011;
   localparam logic [4:0] OP_RECV_INP  = 5'b00100;
   localparam logic [4:0] OP_RECV_WT   = 5'b00101;
   localparam logic [4:0] OP_TX_OUT    = 5'b00110;
   localparam logic [4:0] OP_NOP       = 5'b11111;

   // Field positions within a 64-bit instruction
   localparam int OPC_MSB  = 63;
   localparam int OPC_LSB  = 59;
   localparam int ADDR_MSB = 58;
   localparam int ADDR_LSB = 43;
   localparam int DATA_MSB = 42;
   localparam int DATA_LSB = 27;

   // True for any opcode the decoder understands, including the two idle codes.
   function automatic logic is_legal_op(input logic [4:0] op);
      logic legal;
      case (op)
         OP_NONE, OP_MAC, OP_SEND_WT, OP_STORE_OUT,
         OP_RECV_INP, OP_RECV_WT, OP_TX_OUT, OP_NOP: legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
      return legal;
   endfunction

   // True only for opcodes that carry work; idle codes are never worth queueing.
   function automatic logic is_work_op(input logic [4:0] op);
      return is_legal_op(op) && (op != OP_NONE) && (op != OP_NOP);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x IW storage array with one synchronous write port and one
// asynchronous read port, used as the payload store of the issue queue.
module sync_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int IW    = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [IW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [IW-1:0] o_rdata
);

   logic [IW-1:0] r_mem [DEPTH];

   // Write the incoming entry into its slot.
   // NOTE: the array has no reset; occupancy is tracked by the pointers and
   // count, so stale contents are never observed and the storage maps to RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers host instructions and issues at most one
// per clock into a registered instruction output, inserting opcode 0 when
// nothing is issued. Optional build macro ILLEGAL_OP_FILTER_EN drops
// unknown and idle opcodes at push and raises a sticky err_illegal flag.
module instr_issue_queue
   import ctrl_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IW    = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [IW-1:0]            host_instr,
   input  logic                     host_valid,
   output logic                     host_ready,
   input  logic                     stall,
   input  logic                     flush,
   output logic [IW-1:0]            instruction,
   output logic                     issue_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     err_illegal
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic [IW-1:0] r_instruction;
   logic          r_issue_valid;
   logic [IW-1:0] w_head;
   logic          w_full;
   logic          w_empty;
   logic          w_push_ok;
   logic          w_store;
   logic          w_pop;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // A handshake in a flush cycle completes on the host side but is discarded.
   assign w_push_ok = host_valid && !w_full && !flush;
   assign w_pop     = !stall && !flush && !w_empty;

`ifdef ILLEGAL_OP_FILTER_EN
   logic [4:0] w_opcode;
   logic       r_err_illegal;

   assign w_opcode = host_instr[IW-1 -: 5];
   assign w_store  = w_push_ok && is_work_op(w_opcode);

   // Latch any accepted unknown opcode until the next reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_illegal <= 1'b0;
      end else if (w_push_ok && !is_legal_op(w_opcode)) begin
         r_err_illegal <= 1'b1;
      end
   end

   assign err_illegal = r_err_illegal;
`else
   assign w_store     = w_push_ok;
   assign err_illegal = 1'b0;
`endif

   sync_fifo_mem #(
      .DEPTH (DEPTH),
      .IW    (IW),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_store),
      .i_waddr (r_wr_ptr),
      .i_wdata (host_instr),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );

   // Next occupancy from this cycle's store and pop; flush overrides both.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_count_nxt = r_count;
      if (flush) begin
         w_count_nxt = '0;
      end else begin
         case ({w_store, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Advance pointers and count; pointers wrap naturally at DEPTH.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_store) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
      end
   end

   // Issue register: head entry when popping, otherwise the all-zero no-op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instruction <= '0;
         r_issue_valid <= 1'b0;
      end else if (w_pop) begin
         r_instruction <= w_head;
         r_issue_valid <= 1'b1;
      end else begin
         r_instruction <= '0;
         r_issue_valid <= 1'b0;
      end
   end

   assign host_ready  = !w_full;
   assign instruction = r_instruction;
   assign issue_valid = r_issue_valid;
   assign count       = r_count;
   assign empty       = w_empty;
   assign full        = w_full;

endmodule
